// File: rtl/jnw_spi_pkg.sv
// Shared constants, register map and FSM state type for the SPI register bank.
package jnw_spi_pkg;

  localparam int FRAME_BITS = 16;
  localparam int HDR_BITS   = 8;
  localparam int ADDR_W     = 3;
  localparam int CNT_W      = 5;

  localparam logic [CNT_W-1:0] HDR_LAST   = CNT_W'(HDR_BITS - 1);
  localparam logic [CNT_W-1:0] FRAME_LAST = CNT_W'(FRAME_BITS - 1);

  localparam logic [ADDR_W-1:0] REG_CTRL0  = 3'd0;
  localparam logic [ADDR_W-1:0] REG_CTRL1  = 3'd1;
  localparam logic [ADDR_W-1:0] REG_CTRL2  = 3'd2;
  localparam logic [ADDR_W-1:0] REG_CTRL3  = 3'd3;
  localparam logic [ADDR_W-1:0] REG_STATUS = 3'd4;

  typedef enum logic [1:0] {
    IDLE,
    HDR,
    DATA,
    DONE
  } state_e;

endpackage

// File: rtl/jnw_sync.sv
// Multi-flop synchronizer for one asynchronous input; reset value selectable.
module jnw_sync #(
  parameter int   STAGES  = 2,
  parameter logic RST_VAL = 1'b0
) (
  input  logic clk,
  input  logic rst_n,
  input  logic d_i,
  output logic q_o
);

  logic [STAGES-1:0] sync_d;
  logic [STAGES-1:0] sync_q;

  // Shift the raw input one stage deeper every clock.
  always_comb begin
    sync_d = {sync_q[STAGES-2:0], d_i};
  end

  // Synchronizer chain, forced to the idle level while in reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_q <= {STAGES{RST_VAL}};
    end else begin
      sync_q <= sync_d;
    end
  end

  assign q_o = sync_q[STAGES-1];

endmodule

// File: rtl/jnw_spi_regbank.sv
// SPI mode-0 slave holding four control registers and one read-only status byte.
module jnw_spi_regbank
  import jnw_spi_pkg::*;
#(
  parameter int         SYNC_STAGES = 2,
  parameter logic [7:0] RESET_VAL   = 8'h00
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        sclk_i,
  input  logic        cs_n_i,
  input  logic        mosi_i,
  output logic        miso_o,
  output logic        miso_oe_o,
  input  logic [7:0]  status_i,
  output logic [31:0] regs_o,
  output logic        wr_stb_o,
  output logic [1:0]  wr_addr_o
);

  logic sclk_s;
  logic cs_n_s;
  logic mosi_s;

  logic sclk_prev_q, sclk_prev_d;
  logic cs_n_prev_q, cs_n_prev_d;

  state_e             state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [7:0]         rx_q, rx_d;
  logic [7:0]         tx_q, tx_d;
  logic               rw_q, rw_d;
  logic [ADDR_W-1:0]  addr_q, addr_d;
  logic               wr_pend_q, wr_pend_d;
  logic [7:0]         regs_q [4];
  logic [7:0]         regs_d [4];
  logic               miso_q, miso_d;
  logic               miso_oe_q, miso_oe_d;
  logic               wr_stb_q, wr_stb_d;
  logic [1:0]         wr_addr_q, wr_addr_d;

  logic               sclk_rise;
  logic               sclk_fall;
  logic               cs_fall;
  logic               cs_rise;
  logic [ADDR_W-1:0]  hdr_addr;
  logic [7:0]         rdata;

  jnw_sync #(.STAGES(SYNC_STAGES), .RST_VAL(1'b0)) u_sync_sclk (
    .clk   (clk),
    .rst_n (rst_n),
    .d_i   (sclk_i),
    .q_o   (sclk_s)
  );

  // Chip select idles high so that leaving reset never looks like a frame start.
  jnw_sync #(.STAGES(SYNC_STAGES), .RST_VAL(1'b1)) u_sync_cs_n (
    .clk   (clk),
    .rst_n (rst_n),
    .d_i   (cs_n_i),
    .q_o   (cs_n_s)
  );

  jnw_sync #(.STAGES(SYNC_STAGES), .RST_VAL(1'b0)) u_sync_mosi (
    .clk   (clk),
    .rst_n (rst_n),
    .d_i   (mosi_i),
    .q_o   (mosi_s)
  );

  assign sclk_rise = sclk_s & ~sclk_prev_q;
  assign sclk_fall = ~sclk_s & sclk_prev_q;
  assign cs_fall   = ~cs_n_s & cs_n_prev_q;
  assign cs_rise   = cs_n_s & ~cs_n_prev_q;

  // Address as it will look once the eighth header bit is shifted in.
  assign hdr_addr  = {rx_q[1:0], mosi_s};

  // Read mux for the byte returned in the data phase.
  always_comb begin
    rdata = 8'h00;
    case (hdr_addr)
      REG_CTRL0:  rdata = regs_q[0];
      REG_CTRL1:  rdata = regs_q[1];
      REG_CTRL2:  rdata = regs_q[2];
      REG_CTRL3:  rdata = regs_q[3];
      REG_STATUS: rdata = status_i;
      default:    rdata = 8'h00;
    endcase
  end

  // Frame FSM: header/data shifting, MISO generation and the deferred register write.
  always_comb begin
    sclk_prev_d = sclk_s;
    cs_n_prev_d = cs_n_s;
    state_d     = state_q;
    cnt_d       = cnt_q;
    rx_d        = rx_q;
    tx_d        = tx_q;
    rw_d        = rw_q;
    addr_d      = addr_q;
    wr_pend_d   = wr_pend_q;
    regs_d      = regs_q;
    miso_d      = miso_q;
    miso_oe_d   = miso_oe_q;
    wr_stb_d    = 1'b0;
    wr_addr_d   = wr_addr_q;

    if (wr_pend_q) begin
      regs_d[addr_q[1:0]] = rx_q;
      wr_stb_d            = 1'b1;
      wr_addr_d           = addr_q[1:0];
      wr_pend_d           = 1'b0;
    end

    case (state_q)
      IDLE: begin
        if (cs_fall) begin
          state_d   = HDR;
          cnt_d     = '0;
          rx_d      = 8'h00;
          tx_d      = 8'h00;
          miso_d    = 1'b0;
          miso_oe_d = 1'b1;
        end
      end
      HDR: begin
        if (sclk_rise) begin
          rx_d  = {rx_q[6:0], mosi_s};
          cnt_d = cnt_q + 1'b1;
          if (cnt_q == HDR_LAST) begin
            rw_d    = rx_q[6];
            addr_d  = hdr_addr;
            tx_d    = rx_q[6] ? rdata : 8'h00;
            state_d = DATA;
          end
        end
      end
      DATA: begin
        if (sclk_rise) begin
          rx_d  = {rx_q[6:0], mosi_s};
          cnt_d = cnt_q + 1'b1;
          if (cnt_q == FRAME_LAST) begin
            state_d   = DONE;
            wr_pend_d = ~rw_q & ~addr_q[2];
          end
        end else if (sclk_fall) begin
          miso_d = tx_q[7];
          tx_d   = {tx_q[6:0], 1'b0};
        end
      end
      DONE: begin
        cnt_d = cnt_q;
      end
      default: begin
        state_d = IDLE;
      end
    endcase

    if ((state_q != IDLE) && cs_rise) begin
      state_d   = IDLE;
      miso_oe_d = 1'b0;
      miso_d    = 1'b0;
    end
  end

  // State and output registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sclk_prev_q <= 1'b0;
      cs_n_prev_q <= 1'b1;
      state_q     <= IDLE;
      cnt_q       <= '0;
      rx_q        <= 8'h00;
      tx_q        <= 8'h00;
      rw_q        <= 1'b0;
      addr_q      <= '0;
      wr_pend_q   <= 1'b0;
      regs_q[0]   <= RESET_VAL;
      regs_q[1]   <= RESET_VAL;
      regs_q[2]   <= RESET_VAL;
      regs_q[3]   <= RESET_VAL;
      miso_q      <= 1'b0;
      miso_oe_q   <= 1'b0;
      wr_stb_q    <= 1'b0;
      wr_addr_q   <= 2'd0;
    end else begin
      sclk_prev_q <= sclk_prev_d;
      cs_n_prev_q <= cs_n_prev_d;
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      rx_q        <= rx_d;
      tx_q        <= tx_d;
      rw_q        <= rw_d;
      addr_q      <= addr_d;
      wr_pend_q   <= wr_pend_d;
      regs_q      <= regs_d;
      miso_q      <= miso_d;
      miso_oe_q   <= miso_oe_d;
      wr_stb_q    <= wr_stb_d;
      wr_addr_q   <= wr_addr_d;
    end
  end

  assign regs_o    = {regs_q[3], regs_q[2], regs_q[1], regs_q[0]};
  assign miso_o    = miso_q;
  assign miso_oe_o = miso_oe_q;
  assign wr_stb_o  = wr_stb_q;
  assign wr_addr_o = wr_addr_q;

endmodule
